// File: rtl/median_3x3_core_pkg.sv
// Shared types and constants for the streaming 3x3 median filter core.
package median_3x3_core_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned WORD_W   = PIX_W * LANES;
  localparam int unsigned ROWS     = 3;
  localparam int unsigned WIN_COLS = LANES + 2;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t lo;
    pixel_t mid;
    pixel_t hi;
  } col_t;

  function automatic pixel_t lane_of(logic [WORD_W-1:0] w, int unsigned i);
    return w[i*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/median_3x3_core_sort3.sv
// Combinational 3-input unsigned sorter; doubles as min/median/max primitive.
module median_3x3_core_sort3
  import median_3x3_core_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [PIX_W-1:0] c_i,
  output logic [PIX_W-1:0] lo_o,
  output logic [PIX_W-1:0] mid_o,
  output logic [PIX_W-1:0] hi_o
);

  pixel_t ab_lo, ab_hi, rest;

  assign ab_lo = (a_i < b_i) ? a_i : b_i;
  assign ab_hi = (a_i < b_i) ? b_i : a_i;
  assign hi_o  = (ab_hi > c_i) ? ab_hi : c_i;
  // Whichever of ab_hi/c_i lost the max compare competes with ab_lo for the low slot.
  assign rest  = (ab_hi > c_i) ? c_i : ab_hi;
  assign lo_o  = (ab_lo < rest) ? ab_lo : rest;
  assign mid_o = (ab_lo < rest) ? rest : ab_lo;

endmodule

// File: rtl/median_3x3_core.sv
// Streaming 3x3 median filter: one 4-pixel word per cycle, 3-cycle fixed latency.
module median_3x3_core
  import median_3x3_core_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic        flush,
  output logic [7:0]  pixel1,
  output logic [7:0]  pixel2,
  output logic [7:0]  pixel3,
  output logic [7:0]  pixel4,
  output logic        out_valid
);

  localparam int unsigned CntW = $clog2(LINE_WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(LINE_WORDS - 1);

  logic [WORD_W-1:0] w_in [ROWS];
  logic [WORD_W-1:0] h_q  [ROWS];
  logic [WORD_W-1:0] h_d  [ROWS];
  pixel_t            lp_q [ROWS];
  pixel_t            lp_d [ROWS];
  logic              hold_valid_q, hold_valid_d;
  logic              h_first_q, h_first_d;
  logic              h_last_q, h_last_d;
  logic [CntW-1:0]   col_cnt_q, col_cnt_d;
  logic              emit;
  pixel_t            win [WIN_COLS][ROWS];

  assign w_in[0] = word0;
  assign w_in[1] = word1;
  assign w_in[2] = word2;

  always_comb begin
    hold_valid_d = hold_valid_q;
    h_first_d    = h_first_q;
    h_last_d     = h_last_q;
    col_cnt_d    = col_cnt_q;
    h_d          = h_q;
    lp_d         = lp_q;
    emit         = hold_valid_q & (in_valid | flush);
    if (in_valid) begin
      hold_valid_d = 1'b1;
      h_first_d    = (col_cnt_q == '0);
      h_last_d     = (col_cnt_q == LastCnt);
      col_cnt_d    = (col_cnt_q == LastCnt) ? '0 : col_cnt_q + 1'b1;
      for (int unsigned r = 0; r < ROWS; r++) begin
        h_d[r]  = w_in[r];
        lp_d[r] = lane_of(h_q[r], LANES - 1);
      end
    end else if (flush) begin
      hold_valid_d = 1'b0;
      col_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      h_first_q    <= 1'b0;
      h_last_q     <= 1'b0;
      col_cnt_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      h_first_q    <= h_first_d;
      h_last_q     <= h_last_d;
      col_cnt_q    <= col_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    h_q  <= h_d;
    lp_q <= lp_d;
  end

  // Six-column window around H with horizontal edge replication.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      win[0][r] = h_first_q ? lane_of(h_q[r], 0) : lp_q[r];
      for (int unsigned i = 0; i < LANES; i++) begin
        win[i+1][r] = lane_of(h_q[r], i);
      end
      win[WIN_COLS-1][r] = (in_valid && !h_last_q) ? lane_of(w_in[r], 0)
                                                   : lane_of(h_q[r], LANES - 1);
    end
  end

  // Stage 1: sort each window column.
  pixel_t s1_lo_d  [WIN_COLS];
  pixel_t s1_mid_d [WIN_COLS];
  pixel_t s1_hi_d  [WIN_COLS];
  col_t   s1_q     [WIN_COLS];
  logic   s1_valid_q;

  for (genvar c = 0; c < WIN_COLS; c++) begin : g_s1
    median_3x3_core_sort3 u_sort3 (
      .a_i  (win[c][0]),
      .b_i  (win[c][1]),
      .c_i  (win[c][2]),
      .lo_o (s1_lo_d[c]),
      .mid_o(s1_mid_d[c]),
      .hi_o (s1_hi_d[c])
    );
    always_ff @(posedge clk) begin
      s1_q[c] <= '{lo: s1_lo_d[c], mid: s1_mid_d[c], hi: s1_hi_d[c]};
    end
  end

  // Stage 2: per lane, A = max(lo), B = med(mid), C = min(hi); stored as lo/mid/hi.
  col_t s2_d [LANES];
  col_t s2_q [LANES];
  logic s2_valid_q;

  for (genvar j = 0; j < LANES; j++) begin : g_s2
    pixel_t lo_min, lo_mid, lo_max, md_min, md_mid, md_max, hi_min, hi_mid, hi_max;
    logic   unused_sort;

    median_3x3_core_sort3 u_lo (
      .a_i  (s1_q[j].lo),
      .b_i  (s1_q[j+1].lo),
      .c_i  (s1_q[j+2].lo),
      .lo_o (lo_min),
      .mid_o(lo_mid),
      .hi_o (lo_max)
    );
    median_3x3_core_sort3 u_md (
      .a_i  (s1_q[j].mid),
      .b_i  (s1_q[j+1].mid),
      .c_i  (s1_q[j+2].mid),
      .lo_o (md_min),
      .mid_o(md_mid),
      .hi_o (md_max)
    );
    median_3x3_core_sort3 u_hi (
      .a_i  (s1_q[j].hi),
      .b_i  (s1_q[j+1].hi),
      .c_i  (s1_q[j+2].hi),
      .lo_o (hi_min),
      .mid_o(hi_mid),
      .hi_o (hi_max)
    );
    assign s2_d[j]     = '{lo: lo_max, mid: md_mid, hi: hi_min};
    assign unused_sort = ^{lo_min, lo_mid, md_min, md_max, hi_mid, hi_max};

    always_ff @(posedge clk) begin
      s2_q[j] <= s2_d[j];
    end
  end

  // Stage 3: median of A, B, C drives the output registers.
  pixel_t med_d [LANES];
  pixel_t pix_q [LANES];
  logic   out_valid_q;

  for (genvar j = 0; j < LANES; j++) begin : g_s3
    pixel_t m_lo, m_hi;
    logic   unused_sort;

    median_3x3_core_sort3 u_sort3 (
      .a_i  (s2_q[j].lo),
      .b_i  (s2_q[j].mid),
      .c_i  (s2_q[j].hi),
      .lo_o (m_lo),
      .mid_o(med_d[j]),
      .hi_o (m_hi)
    );
    assign unused_sort = ^{m_lo, m_hi};

    always_ff @(posedge clk) begin
      if (rst) begin
        pix_q[j] <= '0;
      end else if (s2_valid_q) begin
        pix_q[j] <= med_d[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= emit;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
    end
  end

  assign pixel1    = pix_q[0];
  assign pixel2    = pix_q[1];
  assign pixel3    = pix_q[2];
  assign pixel4    = pix_q[3];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_median_3x3_core.sv
// Bench for median_3x3_core: image-level reference model (words placed on lines,
// neighbours fetched with edge replication, 9-value sort) plus directed checks.
module tb_median_3x3_core;

  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] word0, word1, word2;
  logic        flush;
  logic [7:0]  pixel1, pixel2, pixel3, pixel4;
  logic        out_valid;

  median_3x3_core #(
    .LINE_WORDS(L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .word0    (word0),
    .word1    (word1),
    .word2    (word2),
    .flush    (flush),
    .pixel1   (pixel1),
    .pixel2   (pixel2),
    .pixel3   (pixel3),
    .pixel4   (pixel4),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] pix;
  } exp_t;

  exp_t        exp_q[$];
  logic [95:0] acc[$];       // words of the current frame, in arrival order
  logic [31:0] last_pix;
  int          cyc;
  int          n_vec;
  int          n_err;

  // Pixel at row r, word-local column c (-1..4) around word k of the frame.
  function automatic logic [7:0] gpx(int k, int r, int c, bit has_next, logic [95:0] nxt);
    logic [95:0] a;
    logic [31:0] own, prv;
    int          pos;
    a   = acc[k];
    own = a[32*r +: 32];
    pos = k % L;
    if (c < 0) begin
      if (pos == 0) return own[7:0];
      a   = acc[k-1];
      prv = a[32*r +: 32];
      return prv[31:24];
    end
    if (c > 3) begin
      if (pos == L - 1 || !has_next) return own[31:24];
      return nxt[32*r +: 8];
    end
    return own[8*c +: 8];
  endfunction

  function automatic logic [7:0] median9(logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
      end
    end
    return s[4];
  endfunction

  task automatic emit(int k, bit has_next, logic [95:0] nxt, int due);
    exp_t       e;
    logic [7:0] v [9];
    int         n;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      for (int r = 0; r < 3; r++) begin
        for (int c = j - 1; c <= j + 1; c++) begin
          v[n] = gpx(k, r, c, has_next, nxt);
          n++;
        end
      end
      e.pix[8*j +: 8] = median9(v);
    end
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] ep;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev       = 1'b1;
      ep       = exp_q[0].pix;
      last_pix = ep;
      exp_q.delete(0);
    end else begin
      ev = 1'b0;
      ep = last_pix;
    end
    n_vec++;
    assert (out_valid === ev) else begin
      n_err++;
      $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, ev);
    end
    n_vec++;
    assert ({pixel4, pixel3, pixel2, pixel1} === ep) else begin
      n_err++;
      $error("FAIL pixels cyc=%0d observed=%h expected=%h", cyc,
             {pixel4, pixel3, pixel2, pixel1}, ep);
    end
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(bit r, bit iv, logic [95:0] w, bit fl);
    rst                   = r;
    in_valid              = iv;
    {word2, word1, word0} = w;
    flush                 = fl;
    if (r) begin
      acc.delete();
      exp_q.delete();
      last_pix = '0;
    end else if (iv) begin
      if (acc.size() > 0) emit(acc.size() - 1, 1'b1, w, cyc + 3);
      acc.push_back(w);
    end else if (fl) begin
      if (acc.size() > 0) emit(acc.size() - 1, 1'b0, '0, cyc + 3);
      acc.delete();
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] rows3(logic [31:0] x);
    return {x, x, x};
  endfunction

  initial begin
    logic [95:0] w;
    int unsigned sel;
    cyc      = 0;
    n_vec    = 0;
    n_err    = 0;
    last_pix = '0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0);
    idle(2);

    // Flat image: 8 words then flush
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rows3(32'h5555_5555), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Impulse in the middle row of word 1
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, {32'h0, 32'h00FF_0000, 32'h0}, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Left edge replication
    step(1'b0, 1'b1, rows3(32'h281E_140A), 1'b0);
    step(1'b0, 1'b1, rows3(32'h3C3C_3C32), 1'b0);
    idle(2);
    chk("left_edge_pixel1", pixel1, 8'd10);
    chk("left_edge_pixel4", pixel4, 8'd40);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Right edge at end of line: next line's 200s must not leak in
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rows3(32'h1111_1111), 1'b0);
    step(1'b0, 1'b1, rows3(32'h0403_0201), 1'b0);
    step(1'b0, 1'b1, rows3(32'hC8C8_C8C8), 1'b0);
    idle(2);
    chk("right_edge_pixel4", pixel4, 8'd4);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Flush cases: single word, empty hold, flush alongside in_valid
    step(1'b0, 1'b1, rows3(32'h0908_0706), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);
    step(1'b0, 1'b1, rows3(32'h4030_2010), 1'b1);
    step(1'b0, 1'b1, rows3(32'h8070_6050), 1'b1);
    idle(1);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Reset with emissions in flight; next word starts a fresh line
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("reset_pixel1", pixel1, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Randomized traffic with gaps, flushes, rare resets, and tie-heavy data
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      w   = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) w = w & {24{4'h3}};
      if (sel < 1)       step(1'b1, 1'b0, '0, 1'b0);
      else if (sel < 6)  step(1'b0, 1'($urandom_range(0, 1)), w, 1'b1);
      else if (sel < 80) step(1'b0, 1'b1, w, 1'b0);
      else               step(1'b0, 1'b0, w, 1'b0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
